// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage MIPS pipeline.
// Holds a word-addressed data memory, sequences multi-cycle loads/stores,
// stalls upstream stages while an access is in flight, and produces the
// MEM/WB pipeline register. Branch resolution is forwarded to IF as-is.
module mem_access_stage #(
  parameter int ADDR_W  = 7,
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        XM_MemtoReg,
  input  logic        XM_RegWrite,
  input  logic        XM_MemRead,
  input  logic        XM_MemWrite,
  input  logic        XM_branch,
  input  logic [31:0] ALUout,
  input  logic [4:0]  XM_RD,
  input  logic [31:0] XM_MD,
  input  logic [31:0] XM_BT,
  output logic        MW_MemtoReg,
  output logic        MW_RegWrite,
  output logic [31:0] MW_ALUout,
  output logic [31:0] MW_MDout,
  output logic [4:0]  MW_RD,
  output logic        PCSrc,
  output logic [31:0] BT,
  output logic        mem_stall,
  output logic        mem_misalign
);

  // Counter is at least one bit wide so MEM_LAT==1 still elaborates cleanly.
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_LAT - 1);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_stall;
  logic               w_memop;
  logic               w_is_load;
  logic               w_we;
  logic [ADDR_W-1:0]  w_idx;
  logic [31:0]        r_mem [DEPTH];

  assign w_memop   = XM_MemRead | XM_MemWrite;
  // A simultaneous read+write request is serviced as a store only.
  assign w_is_load = XM_MemRead & ~XM_MemWrite;
  // Byte offset and bits above the array size are dropped, so addresses wrap.
  assign w_idx     = ALUout[ADDR_W+1:2];
  // Store commits only on the completion edge, i.e. exactly once per sw.
  assign w_we      = XM_MemWrite & ~w_stall;

  assign PCSrc     = XM_branch;
  assign BT        = XM_BT;
  assign mem_stall = w_stall;

  // Access sequencer state and latency counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state and stall decode; stall is held until the last latency cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stall     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_memop && (MEM_LAT > 1)) begin
          w_stall     = 1'b1;
          w_cnt_nxt   = CNT_W'(1);
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (r_cnt < LAST) begin
          w_stall   = 1'b1;
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end else begin
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Data memory; cleared on reset so an aborted store leaves no trace.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_we) begin
      r_mem[w_idx] <= XM_MD;
    end
  end

  // MEM/WB register: bubble while stalled, otherwise latch the instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      MW_MemtoReg  <= 1'b0;
      MW_RegWrite  <= 1'b0;
      MW_ALUout    <= '0;
      MW_MDout     <= '0;
      MW_RD        <= '0;
      mem_misalign <= 1'b0;
    end else if (w_stall) begin
      MW_MemtoReg  <= 1'b0;
      MW_RegWrite  <= 1'b0;
      MW_ALUout    <= '0;
      MW_MDout     <= '0;
      MW_RD        <= '0;
      mem_misalign <= 1'b0;
    end else begin
      MW_MemtoReg  <= XM_MemtoReg;
      MW_RegWrite  <= XM_RegWrite;
      MW_ALUout    <= ALUout;
      MW_MDout     <= w_is_load ? r_mem[w_idx] : 32'h0;
      MW_RD        <= XM_RD;
      mem_misalign <= w_memop & (|ALUout[1:0]);
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: three instances with MEM_LAT 1, 2, 3
// share one stimulus bus; each scenario resets and observes one instance.
module tb_mem_access_stage;

  logic        clk;
  logic        rst;
  logic        m2r, rw, mr, mw, br;
  logic [31:0] alu, md, bt;
  logic [4:0]  rd;

  logic [3:1]        o_m2r, o_rw, o_pcsrc, o_stall, o_mis;
  logic [3:1][31:0]  o_alu, o_mdo, o_bt;
  logic [3:1][4:0]   o_rd;

  int ncmp = 0;
  int nerr = 0;

  for (genvar g = 1; g <= 3; g++) begin : g_dut
    mem_access_stage #(.ADDR_W(7), .MEM_LAT(g)) u_dut (
      .clk(clk), .rst(rst),
      .XM_MemtoReg(m2r), .XM_RegWrite(rw), .XM_MemRead(mr), .XM_MemWrite(mw),
      .XM_branch(br), .ALUout(alu), .XM_RD(rd), .XM_MD(md), .XM_BT(bt),
      .MW_MemtoReg(o_m2r[g]), .MW_RegWrite(o_rw[g]), .MW_ALUout(o_alu[g]),
      .MW_MDout(o_mdo[g]), .MW_RD(o_rd[g]), .PCSrc(o_pcsrc[g]), .BT(o_bt[g]),
      .mem_stall(o_stall[g]), .mem_misalign(o_mis[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic i_mr, input logic i_mw, input logic i_m2r,
                       input logic i_rw, input logic i_br, input logic [31:0] i_alu,
                       input logic [4:0] i_rd, input logic [31:0] i_md,
                       input logic [31:0] i_bt);
    mr = i_mr; mw = i_mw; m2r = i_m2r; rw = i_rw; br = i_br;
    alu = i_alu; rd = i_rd; md = i_md; bt = i_bt;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 32'h0, 5'd0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    nop();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    nop();
    rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    for (int g = 1; g <= 3; g++) begin
      if (o_rw[g] !== 1'b0 || o_m2r[g] !== 1'b0) begin nerr++; $display("FAIL rst_ctl[%0d]: got rw=%b m2r=%b, expected 0 0", g, o_rw[g], o_m2r[g]); end ncmp++;
      if (o_alu[g] !== 32'h0 || o_mdo[g] !== 32'h0 || o_rd[g] !== 5'd0) begin nerr++; $display("FAIL rst_data[%0d]: got alu=%h md=%h rd=%0d, expected 0", g, o_alu[g], o_mdo[g], o_rd[g]); end ncmp++;
      if (o_stall[g] !== 1'b0 || o_mis[g] !== 1'b0) begin nerr++; $display("FAIL rst_stall[%0d]: got stall=%b mis=%b, expected 0 0", g, o_stall[g], o_mis[g]); end ncmp++;
    end
    step();
    rst = 1'b0;
  endtask

  task automatic test_store_load();
    do_reset();
    drive(0, 1, 0, 0, 0, 32'h10, 5'd0, 32'hDEADBEEF, 32'h0);
    #1;
    if (o_stall[1] !== 1'b0) begin nerr++; $display("FAIL sl_sw_stall: got %b, expected 0", o_stall[1]); end ncmp++;
    step();
    if (o_rw[1] !== 1'b0 || o_mdo[1] !== 32'h0) begin nerr++; $display("FAIL sl_sw_mw: got rw=%b md=%h, expected 0 0", o_rw[1], o_mdo[1]); end ncmp++;
    drive(1, 0, 1, 1, 0, 32'h10, 5'd8, 32'h0, 32'h0);
    #1;
    if (o_stall[1] !== 1'b0) begin nerr++; $display("FAIL sl_lw_stall: got %b, expected 0", o_stall[1]); end ncmp++;
    step();
    if (o_mdo[1] !== 32'hDEADBEEF) begin nerr++; $display("FAIL sl_mdout: got %h, expected DEADBEEF", o_mdo[1]); end ncmp++;
    if (o_rd[1] !== 5'd8 || o_rw[1] !== 1'b1 || o_m2r[1] !== 1'b1) begin nerr++; $display("FAIL sl_ctl: got rd=%0d rw=%b m2r=%b, expected 8 1 1", o_rd[1], o_rw[1], o_m2r[1]); end ncmp++;
    if (o_alu[1] !== 32'h10 || o_mis[1] !== 1'b0) begin nerr++; $display("FAIL sl_alu: got alu=%h mis=%b, expected 10 0", o_alu[1], o_mis[1]); end ncmp++;
  endtask

  task automatic test_multicycle();
    do_reset();
    drive(0, 1, 0, 0, 0, 32'h30, 5'd0, 32'h12345678, 32'h0);
    for (int c = 0; c < 3; c++) begin
      #1;
      if (o_stall[3] !== (c < 2)) begin nerr++; $display("FAIL mc_sw_stall[%0d]: got %b, expected %b", c, o_stall[3], (c < 2)); end ncmp++;
      step();
    end
    drive(1, 0, 1, 1, 0, 32'h30, 5'd5, 32'h0, 32'h0);
    for (int c = 0; c < 2; c++) begin
      #1;
      if (o_stall[3] !== 1'b1) begin nerr++; $display("FAIL mc_lw_stall[%0d]: got %b, expected 1", c, o_stall[3]); end ncmp++;
      step();
      if (o_rw[3] !== 1'b0 || o_rd[3] !== 5'd0 || o_alu[3] !== 32'h0 || o_mdo[3] !== 32'h0) begin nerr++; $display("FAIL mc_bubble[%0d]: got rw=%b rd=%0d alu=%h md=%h, expected all 0", c, o_rw[3], o_rd[3], o_alu[3], o_mdo[3]); end ncmp++;
    end
    #1;
    if (o_stall[3] !== 1'b0) begin nerr++; $display("FAIL mc_lw_last: got %b, expected 0", o_stall[3]); end ncmp++;
    step();
    if (o_mdo[3] !== 32'h12345678 || o_rd[3] !== 5'd5 || o_rw[3] !== 1'b1) begin nerr++; $display("FAIL mc_result: got md=%h rd=%0d rw=%b, expected 12345678 5 1", o_mdo[3], o_rd[3], o_rw[3]); end ncmp++;
    nop();
    #1;
    if (o_stall[3] !== 1'b0) begin nerr++; $display("FAIL mc_after: got %b, expected 0", o_stall[3]); end ncmp++;
  endtask

  task automatic test_reset_abort();
    do_reset();
    drive(0, 1, 0, 0, 0, 32'h20, 5'd0, 32'hCAFEF00D, 32'h0);
    step();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    nop();
    #1;
    if (o_stall[3] !== 1'b0) begin nerr++; $display("FAIL ab_stall: got %b, expected 0", o_stall[3]); end ncmp++;
    if (o_rw[3] !== 1'b0 || o_m2r[3] !== 1'b0 || o_alu[3] !== 32'h0 || o_mdo[3] !== 32'h0 || o_rd[3] !== 5'd0) begin nerr++; $display("FAIL ab_mw: got rw=%b m2r=%b alu=%h md=%h rd=%0d, expected all 0", o_rw[3], o_m2r[3], o_alu[3], o_mdo[3], o_rd[3]); end ncmp++;
    step();
    drive(1, 0, 1, 1, 0, 32'h20, 5'd6, 32'h0, 32'h0);
    step();
    step();
    #1;
    if (o_stall[3] !== 1'b0) begin nerr++; $display("FAIL ab_lw_last: got %b, expected 0", o_stall[3]); end ncmp++;
    step();
    if (o_mdo[3] !== 32'h0 || o_rw[3] !== 1'b1 || o_rd[3] !== 5'd6) begin nerr++; $display("FAIL ab_lw: got md=%h rw=%b rd=%0d, expected 0 1 6", o_mdo[3], o_rw[3], o_rd[3]); end ncmp++;
  endtask

  task automatic test_misalign_alias();
    do_reset();
    drive(0, 1, 0, 0, 0, 32'h10, 5'd0, 32'hA5A50004, 32'h0);
    step();
    drive(1, 0, 1, 1, 0, 32'h13, 5'd9, 32'h0, 32'h0);
    step();
    if (o_mdo[1] !== 32'hA5A50004) begin nerr++; $display("FAIL mis_data: got %h, expected A5A50004", o_mdo[1]); end ncmp++;
    if (o_mis[1] !== 1'b1 || o_alu[1] !== 32'h13) begin nerr++; $display("FAIL mis_pulse: got mis=%b alu=%h, expected 1 13", o_mis[1], o_alu[1]); end ncmp++;
    nop();
    step();
    if (o_mis[1] !== 1'b0 || o_mdo[1] !== 32'h0) begin nerr++; $display("FAIL mis_clear: got mis=%b md=%h, expected 0 0", o_mis[1], o_mdo[1]); end ncmp++;
    drive(0, 1, 0, 0, 0, 32'h8, 5'd0, 32'h0BADCAFE, 32'h0);
    step();
    drive(1, 0, 1, 1, 0, 32'h208, 5'd10, 32'h0, 32'h0);
    step();
    if (o_mdo[1] !== 32'h0BADCAFE || o_mis[1] !== 1'b0) begin nerr++; $display("FAIL alias: got md=%h mis=%b, expected 0BADCAFE 0", o_mdo[1], o_mis[1]); end ncmp++;
    drive(1, 1, 0, 0, 0, 32'h40, 5'd0, 32'h00000077, 32'h0);
    step();
    if (o_mdo[1] !== 32'h0) begin nerr++; $display("FAIL rdwr_md: got %h, expected 0", o_mdo[1]); end ncmp++;
    drive(1, 0, 1, 1, 0, 32'h40, 5'd11, 32'h0, 32'h0);
    step();
    if (o_mdo[1] !== 32'h00000077) begin nerr++; $display("FAIL rdwr_store: got %h, expected 77", o_mdo[1]); end ncmp++;
  endtask

  task automatic test_branch();
    do_reset();
    drive(0, 0, 0, 1, 1, 32'h55, 5'd2, 32'h0, 32'h40);
    #1;
    if (o_pcsrc[1] !== 1'b1 || o_bt[1] !== 32'h40) begin nerr++; $display("FAIL br_comb: got pcsrc=%b bt=%h, expected 1 40", o_pcsrc[1], o_bt[1]); end ncmp++;
    step();
    if (o_rw[1] !== 1'b1 || o_alu[1] !== 32'h55 || o_rd[1] !== 5'd2 || o_mdo[1] !== 32'h0) begin nerr++; $display("FAIL br_mw: got rw=%b alu=%h rd=%0d md=%h, expected 1 55 2 0", o_rw[1], o_alu[1], o_rd[1], o_mdo[1]); end ncmp++;
    drive(0, 0, 0, 0, 0, 32'h0, 5'd0, 32'h0, 32'h0);
    #1;
    if (o_pcsrc[1] !== 1'b0 || o_bt[1] !== 32'h0) begin nerr++; $display("FAIL br_off: got pcsrc=%b bt=%h, expected 0 0", o_pcsrc[1], o_bt[1]); end ncmp++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(0, 1, 0, 0, 0, 32'h0C, 5'd0, 32'h600DF00D, 32'h0);
    step();
    step();
    drive(0, 0, 0, 1, 0, 32'h7, 5'd3, 32'h0, 32'h0);
    #1;
    if (o_stall[2] !== 1'b0) begin nerr++; $display("FAIL bb_add_stall: got %b, expected 0", o_stall[2]); end ncmp++;
    step();
    if (o_alu[2] !== 32'h7 || o_rd[2] !== 5'd3 || o_rw[2] !== 1'b1) begin nerr++; $display("FAIL bb_add: got alu=%h rd=%0d rw=%b, expected 7 3 1", o_alu[2], o_rd[2], o_rw[2]); end ncmp++;
    drive(1, 0, 1, 1, 0, 32'h0C, 5'd4, 32'h0, 32'h0);
    #1;
    if (o_stall[2] !== 1'b1) begin nerr++; $display("FAIL bb_lw_stall: got %b, expected 1", o_stall[2]); end ncmp++;
    step();
    if (o_rw[2] !== 1'b0 || o_rd[2] !== 5'd0 || o_alu[2] !== 32'h0) begin nerr++; $display("FAIL bb_bubble: got rw=%b rd=%0d alu=%h, expected 0 0 0", o_rw[2], o_rd[2], o_alu[2]); end ncmp++;
    step();
    if (o_mdo[2] !== 32'h600DF00D || o_rd[2] !== 5'd4 || o_rw[2] !== 1'b1) begin nerr++; $display("FAIL bb_lw: got md=%h rd=%0d rw=%b, expected 600DF00D 4 1", o_mdo[2], o_rd[2], o_rw[2]); end ncmp++;
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_multicycle();
    test_reset_abort();
    test_misalign_alias();
    test_branch();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
